// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use stall detection, WB bypass on capture,
// and select generation for the two EX operand forwarding muxes.

module id_ex_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_regwrite_i,
  output logic [1:0]        sel_o
);
  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    sel_o = 2'b00;
    if (ex_valid_i && exmem_regwrite_i && exmem_rd_i != '0 && exmem_rd_i == ex_rs_i)
      sel_o = 2'b10;
    else if (ex_valid_i && memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == ex_rs_i)
      sel_o = 2'b01;
  end
endmodule

module id_ex_fwd_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              regwrite;
    logic              memread;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    wb_hit1, wb_hit2;

  assign stall = !flush && id_valid && ex_q.valid && ex_q.memread && ex_q.rd != '0 &&
                 (ex_q.rd == id_rs1 || ex_q.rd == id_rs2);

  // Regfile write and read in the same cycle: take the value being written.
  assign wb_hit1 = memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs1;
  assign wb_hit2 = memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs2;

  always_comb begin
    ex_d = '0;
    if (!flush && !stall) begin
      ex_d.valid    = id_valid;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.rs1_data = wb_hit1 ? memwb_data : id_rs1_data;
      ex_d.rs2_data = wb_hit2 ? memwb_data : id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.pc       = id_pc;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.ctrl     = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_ctrl     = ex_q.ctrl;

  logic [1:0][REG_AW-1:0] ex_rs;
  logic [1:0][1:0]        fwd_sel;
  assign ex_rs = {ex_q.rs2, ex_q.rs1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .ex_valid_i       (ex_q.valid),
      .ex_rs_i          (ex_rs[g]),
      .exmem_rd_i       (exmem_rd),
      .exmem_regwrite_i (exmem_regwrite),
      .memwb_rd_i       (memwb_rd),
      .memwb_regwrite_i (memwb_regwrite),
      .sel_o            (fwd_sel[g])
    );
  end

  assign fwd_sel_a = fwd_sel[0];
  assign fwd_sel_b = fwd_sel[1];
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: reset, capture, forwarding priority,
// load-use stall, flush, and WB bypass on capture.

module tb_id_ex_fwd_stage;
  logic        clk, rst_n;
  logic        id_valid, id_regwrite, id_memread, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, memwb_data;
  logic [7:0]  id_ctrl;
  logic        exmem_regwrite, memwb_regwrite;
  logic        ex_valid, ex_regwrite, ex_memread, stall;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_sel_a, fwd_sel_b;

  int total = 0;
  int bad   = 0;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .flush(flush), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_ctrl(ex_ctrl),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_regwrite = rw; id_memread = mr;
    id_imm = 32'h0; id_pc = 32'h0; id_ctrl = 8'h0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    exmem_rd = 5'd0; exmem_regwrite = 1'b0;
    memwb_rd = 5'd0; memwb_regwrite = 1'b0; memwb_data = 32'h0;
    #12;
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_sel",   {28'b0, fwd_sel_a, fwd_sel_b}, 32'd0);
    chk("rst_data",  ex_rs1_data, 32'd0);

    // Plain capture
    rst_n = 1'b1;
    set_id(1'b1, 5'd5, 5'd0, 5'd9, 32'h11, 32'h22, 1'b1, 1'b0);
    id_imm = 32'h33; id_pc = 32'h100; id_ctrl = 8'hA5;
    tick();
    chk("cap_valid", {31'b0, ex_valid}, 32'd1);
    chk("cap_rs1",   {27'b0, ex_rs1}, 32'd5);
    chk("cap_rd",    {27'b0, ex_rd}, 32'd9);
    chk("cap_d1",    ex_rs1_data, 32'h11);
    chk("cap_d2",    ex_rs2_data, 32'h22);
    chk("cap_imm",   ex_imm, 32'h33);
    chk("cap_pc",    ex_pc, 32'h100);
    chk("cap_ctrl",  {24'b0, ex_ctrl}, 32'hA5);
    chk("cap_rw",    {31'b0, ex_regwrite}, 32'd1);

    // Forwarding priority on rs1=5; rs2=x0 never forwarded
    exmem_rd = 5'd5; exmem_regwrite = 1'b1; memwb_rd = 5'd5; memwb_regwrite = 1'b1;
    #1;
    chk("sel_a_exmem", {30'b0, fwd_sel_a}, 32'd2);
    exmem_regwrite = 1'b0;
    #1;
    chk("sel_a_memwb", {30'b0, fwd_sel_a}, 32'd1);
    exmem_rd = 5'd0; exmem_regwrite = 1'b1;
    #1;
    chk("sel_b_x0", {30'b0, fwd_sel_b}, 32'd0);

    // Mid-stream async reset with ex_valid=1
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, ex_valid}, 32'd0);
    chk("mrst_sel_a", {30'b0, fwd_sel_a}, 32'd0);
    chk("mrst_pc",    ex_pc, 32'd0);
    chk("mrst_d1",    ex_rs1_data, 32'd0);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, ex_valid}, 32'd1);
    chk("post_rst_pc",    ex_pc, 32'h100);

    // Load-use: lw x7 in EX, add x8,x7,x1 in ID
    set_id(1'b1, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 5'd1, 5'd8, 32'h70, 32'h10, 1'b1, 1'b0);
    #1;
    chk("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("lu_bubble_v",  {31'b0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'b0, ex_regwrite}, 32'd0);
    chk("lu_stall_off", {31'b0, stall}, 32'd0);
    exmem_rd = 5'd7; exmem_regwrite = 1'b1;
    tick();
    exmem_regwrite = 1'b0; memwb_rd = 5'd7; memwb_regwrite = 1'b1; memwb_data = 32'h77;
    #1;
    chk("lu_add_v",  {31'b0, ex_valid}, 32'd1);
    chk("lu_add_rd", {27'b0, ex_rd}, 32'd8);
    chk("lu_sel_a",  {30'b0, fwd_sel_a}, 32'd1);
    chk("lu_sel_b",  {30'b0, fwd_sel_b}, 32'd0);
    memwb_regwrite = 1'b0;

    // Load-use with flush in the same cycle
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 5'd4, 5'd9, 32'h1, 32'h2, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", {31'b0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_rw",    {31'b0, ex_regwrite}, 32'd0);
    chk("fl_rs2",   {27'b0, ex_rs2}, 32'd0);

    // x0 destination load never stalls
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd3, 5'd9, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("x0_stall", {31'b0, stall}, 32'd0);

    // WB bypass on capture; rs2 unmatched, and x0 never bypassed
    set_id(1'b1, 5'd3, 5'd6, 5'd9, 32'h0, 32'h66, 1'b1, 1'b0);
    memwb_rd = 5'd3; memwb_regwrite = 1'b1; memwb_data = 32'hDEADBEEF;
    tick();
    chk("byp_d1", ex_rs1_data, 32'hDEADBEEF);
    chk("byp_d2", ex_rs2_data, 32'h66);
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h5, 32'h6, 1'b1, 1'b0);
    memwb_rd = 5'd0;
    tick();
    chk("byp_x0", ex_rs1_data, 32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
